// File: rtl/drum_seq_pkg.sv
// rtl/drum_seq_pkg.sv - shared defaults and index-width helpers for the drum step sequencer
package drum_seq_pkg;

    localparam int STEPS_DEF    = 16;
    localparam int CHANNELS_DEF = 4;
    localparam int TRIG_LEN_DEF = 4;
    localparam int DIV_W_DEF    = 16;
    localparam int MIN_DIV      = 1;

    function automatic int step_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/trig_pulse_gen.sv
// rtl/trig_pulse_gen.sv - per-channel one-shot: start loads a length, output stays high that many cycles
module trig_pulse_gen #(
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [LW-1:0] len_i,
    input  logic          acc_i,
    output logic          trig_o,
    output logic          accent_o
);

    logic [LW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (start_i) begin
            cnt_d = len_i;
            acc_d = acc_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign trig_o   = (cnt_q != '0);
    assign accent_o = trig_o & acc_q;

endmodule

// File: rtl/drum_step_sequencer.sv
// rtl/drum_step_sequencer.sv - multi-channel step sequencer top; SEQ_ACCENT_EN adds the accent memory
module drum_step_sequencer
    import drum_seq_pkg::*;
#(
    parameter int STEPS    = STEPS_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int TRIG_LEN = TRIG_LEN_DEF,
    parameter int DIV_W    = DIV_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic [DIV_W-1:0]             tempo_div,
    input  logic [step_w(STEPS)-1:0]     last_step,
    input  logic                         tap,
    input  logic [ch_w(CHANNELS)-1:0]    tap_ch,
    input  logic                         wr_en,
    input  logic [ch_w(CHANNELS)-1:0]    wr_ch,
    input  logic [step_w(STEPS)-1:0]     wr_step,
    input  logic                         wr_val,
    input  logic                         wr_acc,
    input  logic [CHANNELS-1:0]          mute,
    output logic [step_w(STEPS)-1:0]     step,
    output logic                         step_tick,
    output logic [CHANNELS-1:0]          trig,
    output logic [CHANNELS-1:0]          accent
);

    localparam int SW = step_w(STEPS);
    localparam int CW = ch_w(CHANNELS);

    logic             run_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SW-1:0]    step_q, step_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] period, plen;
    logic [STEPS-1:0] pat_q [CHANNELS];
    logic [STEPS-1:0] pat_d [CHANNELS];
    logic [CHANNELS-1:0] start, acc_start;

    // Pulse never outlasts the step period, so back-to-back set cells keep a low gap
    always_comb begin
        period = (tempo_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : tempo_div;
        plen   = (period > DIV_W'(TRIG_LEN)) ? DIV_W'(TRIG_LEN) : period;
    end

    always_comb begin
        div_d  = div_q;
        step_d = step_q;
        tick_d = 1'b0;
        if (!run) begin
            div_d = '0;
        end else if (!run_q) begin
            div_d  = '0;
            tick_d = 1'b1;
        end else if (div_q >= period) begin
            div_d  = '0;
            tick_d = 1'b1;
            step_d = (step_q >= last_step) ? '0 : step_q + 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // Event lookup reads the registered pattern, so same-cycle writes land after evaluation
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            start[ch] = tick_d & pat_q[ch][step_d] & ~mute[ch];
            pat_d[ch] = pat_q[ch];
            if (tap && tap_ch == CW'(ch))
                pat_d[ch][step_q] = 1'b1;
            if (wr_en && wr_ch == CW'(ch))
                pat_d[ch][wr_step] = wr_val;
        end
    end

`ifdef SEQ_ACCENT_EN
    logic [STEPS-1:0] acc_q [CHANNELS];
    logic [STEPS-1:0] acc_d [CHANNELS];

    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            acc_start[ch] = acc_q[ch][step_d];
            acc_d[ch]     = acc_q[ch];
            if (tap && tap_ch == CW'(ch))
                acc_d[ch][step_q] = 1'b0;
            if (wr_en && wr_ch == CW'(ch))
                acc_d[ch][wr_step] = wr_acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < CHANNELS; ch++)
                acc_q[ch] <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++)
                acc_q[ch] <= acc_d[ch];
        end
    end
`else
    logic unused_wr_acc;
    assign unused_wr_acc = wr_acc;
    assign acc_start     = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            div_q  <= '0;
            step_q <= '0;
            tick_q <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++)
                pat_q[ch] <= '0;
        end else begin
            run_q  <= run;
            div_q  <= div_d;
            step_q <= step_d;
            tick_q <= tick_d;
            for (int ch = 0; ch < CHANNELS; ch++)
                pat_q[ch] <= pat_d[ch];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_pulse
        trig_pulse_gen #(
            .LW(DIV_W)
        ) u_pulse (
            .clk      (clk),
            .rst_n    (rst_n),
            .start_i  (start[g]),
            .len_i    (plen),
            .acc_i    (acc_start[g]),
            .trig_o   (trig[g]),
            .accent_o (accent[g])
        );
    end

    assign step      = step_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// tb/tb_drum_step_sequencer.sv - scoreboard bench for drum_step_sequencer (SEQ_ACCENT_EN aware)
module tb_drum_step_sequencer;

`ifdef SEQ_ACCENT_EN
    localparam logic [3:0] ACC_EXP = 4'b1000;
`else
    localparam logic [3:0] ACC_EXP = 4'b0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n, run, tap, wr_en, wr_val, wr_acc;
    logic [15:0] tempo_div;
    logic [3:0]  last_step, wr_step, mute, step, trig, accent;
    logic [1:0]  tap_ch, wr_ch;
    logic        step_tick;

    always #5 clk = ~clk;

    drum_step_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .tempo_div(tempo_div), .last_step(last_step),
        .tap(tap), .tap_ch(tap_ch), .wr_en(wr_en), .wr_ch(wr_ch), .wr_step(wr_step),
        .wr_val(wr_val), .wr_acc(wr_acc), .mute(mute), .step(step), .step_tick(step_tick),
        .trig(trig), .accent(accent)
    );

    typedef struct {
        int         step;
        logic [3:0] trig;
        logic [3:0] acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_gap = 4;
    int   exp_len = 3;
    int   cyc = 0;
    int   last_tick = -1;
    int   hi[4];
    int   rise_cnt[4];
    logic [3:0] prev = '0;
    exp_t e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            last_tick = -1;
            prev      = '0;
            for (int i = 0; i < 4; i++) begin
                hi[i]       = 0;
                rise_cnt[i] = 0;
            end
        end else begin
            if (!run) last_tick = -1;
            if (step_tick) begin
                check("tick_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("step", 32'(step), 32'(e.step));
                    check("trig", 32'(trig), 32'(e.trig));
                    check("accent", 32'(accent), 32'(e.acc));
                end
                if (last_tick >= 0) check("tick_gap", 32'(cyc - last_tick), 32'(exp_gap));
                last_tick = cyc;
            end
            for (int i = 0; i < 4; i++) begin
                if (trig[i] && !prev[i]) begin
                    rise_cnt[i]++;
                    hi[i] = 1;
                end else if (trig[i]) begin
                    hi[i]++;
                end else if (prev[i]) begin
                    check("pulse_len", 32'(hi[i]), 32'(exp_len));
                end
            end
            prev = trig;
        end
    end

    task automatic push(input int s, input logic [3:0] t, input logic [3:0] a);
        exp_t x;
        x.step = s;
        x.trig = t;
        x.acc  = a;
        sb.push_back(x);
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) cyc_wait(1);
        check("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        run   = 1'b0;
        mute  = '0;
        rst_n = 1'b0;
        cyc_wait(1);
        rst_n = 1'b1;
        cyc_wait(1);
    endtask

    task automatic stop_run();
        run = 1'b0;
        cyc_wait(8);
    endtask

    task automatic wr_cell(input int ch, input int s, input logic v, input logic a);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_step = 4'(s);
        wr_val  = v;
        wr_acc  = a;
        cyc_wait(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; tempo_div = 16'd3; last_step = 4'd15;
        tap = 1'b0; tap_ch = '0; wr_en = 1'b0; wr_ch = '0; wr_step = '0;
        wr_val = 1'b0; wr_acc = 1'b0; mute = '0;
        cyc_wait(2);
        check("rst_step", 32'(step), 32'd0);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_tick", 32'(step_tick), 32'd0);
        check("rst_accent", 32'(accent), 32'd0);
        rst_n = 1'b1;
        cyc_wait(1);

        // empty pattern: full 16-step loop, tick every 4 cycles
        for (int s = 0; s < 16; s++) push(s, 4'b0000, 4'b0000);
        push(0, 4'b0000, 4'b0000);
        run = 1'b1;
        drain(100);
        stop_run();

        // two adjacent set steps: pulse clipped to 3, two edges
        do_reset();
        wr_cell(0, 0, 1'b1, 1'b0);
        wr_cell(0, 1, 1'b1, 1'b0);
        push(0, 4'b0001, 4'b0000);
        push(1, 4'b0001, 4'b0000);
        push(2, 4'b0000, 4'b0000);
        run = 1'b1;
        drain(40);
        stop_run();
        check("rise_ch0", 32'(rise_cnt[0]), 32'd2);

        // last_step lowered below current step
        do_reset();
        for (int s = 0; s < 10; s++) push(s, 4'b0000, 4'b0000);
        run = 1'b1;
        drain(100);
        last_step = 4'd3;
        push(0, 4'b0000, 4'b0000);
        push(1, 4'b0000, 4'b0000);
        push(2, 4'b0000, 4'b0000);
        push(3, 4'b0000, 4'b0000);
        push(0, 4'b0000, 4'b0000);
        drain(60);
        stop_run();
        last_step = 4'd15;

        // tap while stopped, and write beating tap on the same cell
        do_reset();
        for (int s = 0; s < 6; s++) push(s, 4'b0000, 4'b0000);
        run = 1'b1;
        drain(60);
        run = 1'b0;
        cyc_wait(2);
        tap = 1'b1; tap_ch = 2'd2;
        cyc_wait(1);
        tap_ch = 2'd3;
        wr_en = 1'b1; wr_ch = 2'd3; wr_step = 4'd5; wr_val = 1'b0;
        cyc_wait(1);
        tap = 1'b0; wr_en = 1'b0;
        cyc_wait(2);
        check("held_step", 32'(step), 32'd5);
        push(5, 4'b0100, 4'b0000);
        for (int s = 6; s < 16; s++) push(s, 4'b0000, 4'b0000);
        for (int s = 0; s < 5; s++) push(s, 4'b0000, 4'b0000);
        push(5, 4'b0100, 4'b0000);
        run = 1'b1;
        drain(120);
        stop_run();
        check("rise_ch2", 32'(rise_cnt[2]), 32'd2);
        check("rise_ch3", 32'(rise_cnt[3]), 32'd0);

        // mute sampled only at events; pulse completes when muted mid-pulse
        do_reset();
        for (int s = 0; s < 16; s++) wr_cell(1, s, 1'b1, 1'b0);
        mute = 4'b0010;
        last_step = 4'd3;
        push(0, 4'b0000, 4'b0000);
        push(1, 4'b0000, 4'b0000);
        run = 1'b1;
        drain(40);
        mute = 4'b0000;
        push(2, 4'b0010, 4'b0000);
        drain(20);
        mute = 4'b0010;
        push(3, 4'b0000, 4'b0000);
        drain(20);
        stop_run();
        check("rise_ch1", 32'(rise_cnt[1]), 32'd1);
        last_step = 4'd15;

        // accent cell, full TRIG_LEN pulse with a slower tempo
        do_reset();
        tempo_div = 16'd7; exp_gap = 8; exp_len = 4; last_step = 4'd3;
        wr_cell(3, 2, 1'b1, 1'b1);
        wr_cell(3, 3, 1'b1, 1'b0);
        push(0, 4'b0000, 4'b0000);
        push(1, 4'b0000, 4'b0000);
        push(2, 4'b1000, ACC_EXP);
        push(3, 4'b1000, 4'b0000);
        run = 1'b1;
        drain(60);
        stop_run();
        last_step = 4'd15;

        // tempo_div 0 behaves as 1: one-cycle pulses, period 2
        do_reset();
        tempo_div = 16'd0; exp_gap = 2; exp_len = 1;
        wr_cell(0, 0, 1'b1, 1'b0);
        wr_cell(0, 1, 1'b1, 1'b0);
        push(0, 4'b0001, 4'b0000);
        push(1, 4'b0001, 4'b0000);
        push(2, 4'b0000, 4'b0000);
        run = 1'b1;
        drain(30);
        stop_run();
        check("rise_ch0_fast", 32'(rise_cnt[0]), 32'd2);

        // reset asserted mid-pulse drops trig without a clock
        do_reset();
        tempo_div = 16'd7; exp_gap = 8; exp_len = 4;
        wr_cell(0, 0, 1'b1, 1'b0);
        push(0, 4'b0001, 4'b0000);
        run = 1'b1;
        drain(20);
        check("pulse_active", 32'(trig), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_trig", 32'(trig), 32'h0);
        check("async_step", 32'(step), 32'h0);
        run = 1'b0;
        cyc_wait(2);
        rst_n = 1'b1;
        cyc_wait(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
